bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Destination-side sequencer for the 8-source common bus.
- Accepts queued register-transfer requests (source code, destination index) over a valid/ready handshake.
- Drives the 3-bit bus source select, waits a programmable settle time, then pulses exactly one destination load strobe.
- Sits between the control-sequence logic and the register file's LD inputs; the existing 8:1 bus selector consumes bus_select.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16.
- SETTLE_CYCLES, 1, cycles bus_select is held before the load strobe; legal 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_src  in  3  bus source code to drive onto the selector.
- req_dst  in  3  destination register index (0..7).
- flush  in  1  synchronous abort: empty the queue and drop any unlaunched transfer.
- bus_select  out  3  registered source select to the bus selector.
- ld  out  8  registered one-hot destination load strobes.
- done  out  1  registered pulse, high in the same cycle as the ld strobe.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous, rst_n low):
  - bus_select=0, ld=0, done=0, busy=0.
  - FIFO empty, FSM=IDLE, settle counter=0.
  - req_ready=1 once rst_n is high.
- Handshake:
  - req_ready = !full && !flush (combinational from the occupancy count).
  - No push occurs when full.
  - req_src/req_dst are captured on the accepting edge.
- FSM states IDLE, SETTLE, LOAD:
  - IDLE: if FIFO non-empty, pop the head, register bus_select=src, latch dst, load counter=SETTLE_CYCLES-1. Next state is SETTLE if SETTLE_CYCLES>0, else LOAD.
  - SETTLE: decrement the counter; when it is 0, go to LOAD.
  - LOAD: ld[dst]=1 and done=1 for exactly one cycle.
    - If FIFO non-empty, pop the next entry in this same cycle and go to SETTLE/LOAD as from IDLE (back-to-back).
    - Otherwise go to IDLE.
- Latency: acceptance at edge E0 → bus_select valid after E1 → ld/done high for the cycle after edge E(1+SETTLE_CYCLES).
- Throughput: one transfer per SETTLE_CYCLES+1 cycles sustained.
- bus_select holds its last value in IDLE; it never returns to 0 between transfers (glitch-free bus).
- ld is one-hot or zero; never more than one bit set.
- Push and pop in the same cycle: occupancy unchanged; ordering is strictly FIFO.
- FIFO pointers wrap modulo DEPTH; full when count==DEPTH.
- flush:
  - Empties the FIFO and drops any push in that cycle.
  - SETTLE → IDLE without asserting ld.
  - A strobe already registered for the current LOAD cycle completes; the FSM then goes to IDLE.
  - bus_select is unchanged.
- Reset mid-transfer: ld/done drop immediately (asynchronously) and the queue is lost.

Optional Feature:
- Macro BUS_XFER_CNT_EN.
  - Defined: adds output xfer_count [15:0]. It increments on each done pulse, wraps 16'hFFFF→0, is cleared only by rst_n, and is not affected by flush.
  - Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bus_xfer_pkg:
  - state enum {IDLE, SETTLE, LOAD};
  - SEL_W=3, NDST=8;
  - request struct {src[2:0], dst[2:0]}.
- One sub-module, bus_xfer_fifo, is natural: parameterized synchronous FIFO with push/pop/flush/full/empty/count.
- The FSM, settle counter and 3-to-8 strobe decode stay in bus_xfer_ctrl.

Test Plan:
- Reset then single request src=3, dst=5, SETTLE_CYCLES=1 → bus_select=3 after E1; ld=8'b0010_0000 and done=1 in the cycle after E2 only; busy falls the next cycle.
- SETTLE_CYCLES=0, four back-to-back requests (1→0, 2→1, 4→2, 7→7) → ld pulses on 4 consecutive cycles (01,02,04,80) in order; bus_select follows 1,2,4,7.
- Fill with 4 requests while holding the first in SETTLE (SETTLE_CYCLES=3) → req_ready=0 at count 4; a 5th req_valid is not accepted; req_ready returns to 1 the cycle after the first pop.
- flush asserted during SETTLE with 2 entries queued → no ld pulse, FSM IDLE, FIFO empty, req_ready=0 during the flush cycle, bus_select retains its value.
- rst_n low in the LOAD cycle → ld=0, done=0 immediately; after release, busy=0 and req_ready=1.
- BUS_XFER_CNT_EN defined, 65537 transfers → xfer_count=1 (wrap); an intervening flush does not clear it.

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the common-bus transfer sequencer.
package bus_xfer_pkg;
  localparam int SEL_W = 3;
  localparam int NDST  = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] LOAD   = 2'd2;

  typedef struct packed {
    logic [SEL_W-1:0] src;
    logic [2:0]       dst;
  } xfer_req_t;

  function automatic logic [NDST-1:0] dst_onehot(input logic [2:0] dst);
    dst_onehot      = '0;
    dst_onehot[dst] = 1'b1;
  endfunction
endpackage

// File: rtl/bus_xfer_fifo.sv
// Request queue: power-of-two depth, synchronous flush, head visible on dout.
module bus_xfer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// Destination-side bus transfer sequencer: select source, settle, strobe one LD.
// Optional transfer counter output enabled by defining BUS_XFER_CNT_EN.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_src,
  input  logic [2:0]       req_dst,
  input  logic             flush,
  output logic [SEL_W-1:0] bus_select,
  output logic [NDST-1:0]  ld,
  output logic             done,
  output logic             busy
`ifdef BUS_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);
  localparam int         CW          = $clog2(DEPTH+1);
  localparam logic [1:0] SETTLE_INIT = (SETTLE_CYCLES > 0) ? 2'(SETTLE_CYCLES - 1) : 2'd0;

  logic [1:0]    state;
  logic [1:0]    cnt;
  logic [2:0]    dst_q;
  xfer_req_t     push_req, head;
  logic          fifo_full, fifo_empty, push, pop;
  logic [CW-1:0] fifo_count;

  assign push_req  = '{src: req_src, dst: req_dst};
  assign req_ready = !fifo_full && !flush;
  assign push      = req_valid && req_ready;
  assign pop       = !flush && !fifo_empty && ((state == IDLE) || (state == LOAD));
  assign busy      = (state != IDLE) || (fifo_count != '0);

  bus_xfer_fifo #(.DEPTH(DEPTH), .W($bits(xfer_req_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_req),
    .pop   (pop),
    .dout  (head),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ld/done default low so the strobe lasts exactly one cycle; bus_select only changes on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dst_q      <= '0;
      bus_select <= '0;
      ld         <= '0;
      done       <= 1'b0;
    end else begin
      ld   <= '0;
      done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (pop) begin
            bus_select <= head.src;
            dst_q      <= head.dst;
            if (SETTLE_CYCLES == 0) begin
              state <= LOAD;
              ld    <= dst_onehot(head.dst);
              done  <= 1'b1;
            end else begin
              state <= SETTLE;
              cnt   <= SETTLE_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == 2'd0) begin
            state <= LOAD;
            ld    <= dst_onehot(dst_q);
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    xfer_count <= '0;
    else if (done) xfer_count <= xfer_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench: three instances (SETTLE_CYCLES 1, 0, 3) exercised one at a time.
module tb_bus_xfer_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n, req_valid, flush, req_ready, done, busy;
  logic [2:0][2:0]  req_src, req_dst, bus_select;
  logic [2:0][7:0]  ld;
`ifdef BUS_XFER_CNT_EN
  logic [2:0][15:0] xfer_count;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_xfer_ctrl #(
      .DEPTH(4),
      .SETTLE_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_src    (req_src[g]),
      .req_dst    (req_dst[g]),
      .flush      (flush[g]),
      .bus_select (bus_select[g]),
      .ld         (ld[g]),
      .done       (done[g]),
      .busy       (busy[g])
`ifdef BUS_XFER_CNT_EN
      ,
      .xfer_count (xfer_count[g])
`endif
    );
  end

  typedef struct {
    int         inst;
    logic [2:0] src;
    logic [2:0] dst;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, g, act, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding transfer.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst_n[g] && (ld[g] != 8'h00 || done[g])) begin
        exp_t       e;
        logic [7:0] m;
        if (exp_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_ld inst%0d: got ld=%0h done=%0b expected no strobe", g, ld[g], done[g]);
        end else begin
          e = exp_q.pop_front();
          m = 8'h01 << e.dst;
          chk("xfer_inst", g, 32'(g), 32'(e.inst));
          chk("xfer_ld", g, 32'(ld[g]), 32'(m));
          chk("xfer_done", g, 32'(done[g]), 32'd1);
          chk("xfer_sel", g, 32'(bus_select[g]), 32'(e.src));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [2:0] s, input logic [2:0] d, input bit expect_xfer);
    req_valid[g] = 1'b1;
    req_src[g]   = s;
    req_dst[g]   = d;
    if (expect_xfer) exp_q.push_back('{inst: g, src: s, dst: d});
    tick();
  endtask

  task automatic wait_idle(input int g);
    int k;
    k = 0;
    while (busy[g] && k < 300) begin
      tick();
      k++;
    end
    chk("idle_timeout", g, 32'(busy[g]), 32'd0);
    tick();
  endtask

  logic [2:0] t2_src [4] = '{3'd1, 3'd2, 3'd4, 3'd7};
  logic [2:0] t2_dst [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
  logic [7:0] t2_ld  [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
  logic [2:0] t3_src [5] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd5};
  logic [2:0] t3_dst [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = '1; req_valid = '0; flush = '0; req_src = '0; req_dst = '0;
    #2 rst_n = '0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_sel", g, 32'(bus_select[g]), 32'd0);
      chk("rst_ld", g, 32'(ld[g]), 32'd0);
      chk("rst_done", g, 32'(done[g]), 32'd0);
      chk("rst_busy", g, 32'(busy[g]), 32'd0);
    end
    #1 rst_n = '1;
    tick();
    for (int g = 0; g < 3; g++) chk("rst_ready", g, 32'(req_ready[g]), 32'd1);

    // Single transfer, SETTLE_CYCLES=1
    req_valid[0] = 1'b1; req_src[0] = 3'd3; req_dst[0] = 3'd5;
    exp_q.push_back('{inst: 0, src: 3'd3, dst: 3'd5});
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_e0_ld", 0, 32'(ld[0]), 32'd0);
    chk("t1_e0_sel", 0, 32'(bus_select[0]), 32'd0);
    @(negedge clk);
    chk("t1_e1_sel", 0, 32'(bus_select[0]), 32'd3);
    chk("t1_e1_ld", 0, 32'(ld[0]), 32'd0);
    chk("t1_e1_busy", 0, 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("t1_e2_ld", 0, 32'(ld[0]), 32'h20);
    chk("t1_e2_done", 0, 32'(done[0]), 32'd1);
    @(negedge clk);
    chk("t1_e3_ld", 0, 32'(ld[0]), 32'd0);
    chk("t1_e3_busy", 0, 32'(busy[0]), 32'd0);
    tick();

    // Back-to-back, SETTLE_CYCLES=0
    fork
      begin
        for (int i = 0; i < 4; i++) send(1, t2_src[i], t2_dst[i], 1'b1);
        req_valid[1] = 1'b0;
      end
      begin
        @(negedge clk);
        chk("t2_pre_ld", 1, 32'(ld[1]), 32'd0);
        @(negedge clk);
        chk("t2_e0_ld", 1, 32'(ld[1]), 32'd0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("t2_ld_seq", 1, 32'(ld[1]), 32'(t2_ld[k]));
          chk("t2_sel_seq", 1, 32'(bus_select[1]), 32'(t2_src[k]));
        end
        @(negedge clk);
        chk("t2_end_ld", 1, 32'(ld[1]), 32'd0);
      end
    join
    wait_idle(1);

    // Fill the queue while the first transfer settles, SETTLE_CYCLES=3
    for (int i = 0; i < 5; i++) send(2, t3_src[i], t3_dst[i], 1'b1);
    req_valid[2] = 1'b1; req_src[2] = 3'd0; req_dst[2] = 3'd0;
    @(negedge clk);
    chk("t3_full_ready", 2, 32'(req_ready[2]), 32'd0);
    chk("t3_first_ld", 2, 32'(ld[2]), 32'h02);
    tick();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t3_ready_back", 2, 32'(req_ready[2]), 32'd1);
    wait_idle(2);

    // Flush during SETTLE with two entries queued
    send(2, 3'd4, 3'd0, 1'b0);
    send(2, 3'd2, 3'd5, 1'b0);
    send(2, 3'd3, 3'd6, 1'b0);
    req_valid[2] = 1'b0;
    flush[2]     = 1'b1;
    @(negedge clk);
    chk("t4_flush_ready", 2, 32'(req_ready[2]), 32'd0);
    tick();
    flush[2] = 1'b0;
    @(negedge clk);
    chk("t4_busy", 2, 32'(busy[2]), 32'd0);
    chk("t4_sel_hold", 2, 32'(bus_select[2]), 32'd4);
    repeat (6) tick();
    chk("t4_sel_late", 2, 32'(bus_select[2]), 32'd4);
    chk("t4_ld_late", 2, 32'(ld[2]), 32'd0);

    // Asynchronous reset during the LOAD cycle; the queued second entry is lost
    send(0, 3'd6, 3'd2, 1'b0);
    send(0, 3'd1, 3'd7, 1'b0);
    req_valid[0] = 1'b0;
    tick();
    chk("t5_load_ld", 0, 32'(ld[0]), 32'h04);
    chk("t5_load_done", 0, 32'(done[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    chk("t5_rst_ld", 0, 32'(ld[0]), 32'd0);
    chk("t5_rst_done", 0, 32'(done[0]), 32'd0);
    tick();
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("t5_busy", 0, 32'(busy[0]), 32'd0);
    chk("t5_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("t5_sel", 0, 32'(bus_select[0]), 32'd0);
    tick();

`ifdef BUS_XFER_CNT_EN
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    tick();
    chk("cnt_rst", 1, 32'(xfer_count[1]), 32'd0);
    for (int i = 0; i < 65537; i++) send(1, 3'd3, 3'd3, 1'b1);
    req_valid[1] = 1'b0;
    wait_idle(1);
    chk("cnt_wrap", 1, 32'(xfer_count[1]), 32'd1);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    tick();
    chk("cnt_flush", 1, 32'(xfer_count[1]), 32'd1);
`endif

    repeat (3) tick();
    chk("scoreboard_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
